convergence_check_unit: RTL and testbench



---
 rtl/convergence_check_unit.sv | 133 +++++++++++++
 tb/tb_convergence_check_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/convergence_check_unit.sv
// convergence_check_unit: per-round Manhattan distance of new vs. old centroids,
// seen-mask round tracking and k-means convergence / iteration-limit decision.
module convergence_check_unit #(
  parameter int DIMS     = 7,
  parameter int CORD_W   = 13,
  parameter int CENT_NUM = 8,
  parameter int ITER_W   = 8,
  parameter int DIST_W   = CORD_W + 1 + $clog2(DIMS),
  parameter int SUM_W    = DIST_W + $clog2(CENT_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run_start,
  input  logic                         mode,
  input  logic [SUM_W-1:0]             threshold,
  input  logic [ITER_W-1:0]            max_iter,
  input  logic                         cent_valid,
  input  logic [$clog2(CENT_NUM)-1:0]  cent_idx,
  input  logic [DIMS*CORD_W-1:0]       old_centroid,
  input  logic [DIMS*CORD_W-1:0]       new_centroid_in,
  output logic [DIMS*CORD_W-1:0]       new_centroid_out,
  output logic                         new_centroid_valid,
  output logic                         result_valid,
  input  logic                         result_ack,
  output logic                         has_converged,
  output logic                         iter_limit_hit,
  output logic                         dup_err,
  output logic [ITER_W-1:0]            iter_count,
  output logic [SUM_W-1:0]             round_sum
);
  localparam int IW = $clog2(CENT_NUM);
  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, RESULT} state_t;
  state_t                 state_q;
  logic [DIST_W-1:0]      dist_d, dist_q;
  logic [IW-1:0]          idx_q;
  logic                   v_q, all_under_q, conv_q, lim_q, rv_q, dup_q, nval_q, conv;
  logic [CENT_NUM-1:0]    seen_q, seen_d;
  logic [SUM_W-1:0]       acc_q, round_q;
  logic [ITER_W-1:0]      iter_q;
  logic [ITER_W:0]        iter_inc;
  logic [DIMS*CORD_W-1:0] ncent_q;
  logic [CORD_W:0]        diff, mag;
  // Sign-extend by one bit so the difference and its magnitude never wrap.
  always_comb begin
    dist_d = '0;
    diff = '0;
    mag = '0;
    for (int i = 0; i < DIMS; i++) begin
      diff = {old_centroid[i*CORD_W+CORD_W-1], old_centroid[i*CORD_W +: CORD_W]}
           - {new_centroid_in[i*CORD_W+CORD_W-1], new_centroid_in[i*CORD_W +: CORD_W]};
      mag = diff[CORD_W] ? -diff : diff;
      dist_d = dist_d + DIST_W'(mag);
    end
  end
  assign seen_d   = seen_q | (CENT_NUM'(1) << idx_q);
  assign conv     = mode ? (acc_q < threshold) : all_under_q;
  assign iter_inc = {1'b0, iter_q} + (ITER_W+1)'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dist_q <= '0;
      idx_q <= '0;
      v_q <= 1'b0;
      ncent_q <= '0;
      nval_q <= 1'b0;
      seen_q <= '0;
      acc_q <= '0;
      all_under_q <= 1'b1;
      round_q <= '0;
      conv_q <= 1'b0;
      lim_q <= 1'b0;
      rv_q <= 1'b0;
      dup_q <= 1'b0;
      iter_q <= '0;
    end else begin
      dist_q <= dist_d;
      idx_q <= cent_idx;
      v_q <= cent_valid;
      ncent_q <= new_centroid_in;
      nval_q <= cent_valid;
      if (run_start) begin
        state_q <= COLLECT;
        seen_q <= '0;
        acc_q <= '0;
        all_under_q <= 1'b1;
        dup_q <= 1'b0;
        iter_q <= '0;
        rv_q <= 1'b0;
        conv_q <= 1'b0;
        lim_q <= 1'b0;
      end else begin
        case (state_q)
          COLLECT: if (v_q) begin
            if (seen_q[idx_q]) dup_q <= 1'b1;
            else begin
              seen_q <= seen_d;
              acc_q <= acc_q + SUM_W'(dist_q);
              all_under_q <= all_under_q & (dist_q < threshold[DIST_W-1:0]);
              if (&seen_d) state_q <= DECIDE;
            end
          end
          DECIDE: begin
            round_q <= acc_q;
            conv_q <= conv;
            iter_q <= iter_inc[ITER_W] ? iter_q : iter_inc[ITER_W-1:0];
            lim_q <= !conv && (max_iter != '0) && (iter_inc >= {1'b0, max_iter});
            rv_q <= 1'b1;
            state_q <= RESULT;
          end
          RESULT: if (result_ack) begin
            rv_q <= 1'b0;
            if (conv_q || lim_q) state_q <= IDLE;
            else begin
              seen_q <= '0;
              acc_q <= '0;
              all_under_q <= 1'b1;
              state_q <= COLLECT;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign new_centroid_out   = ncent_q;
  assign new_centroid_valid = nval_q;
  assign result_valid       = rv_q;
  assign has_converged      = conv_q;
  assign iter_limit_hit     = lim_q;
  assign dup_err            = dup_q;
  assign iter_count         = iter_q;
  assign round_sum          = round_q;
endmodule

// File: tb/tb_convergence_check_unit.sv
// tb_convergence_check_unit: directed scenarios with hand-computed expected results.
module tb_convergence_check_unit;
  localparam int DIMS = 7, CORD_W = 13, ITER_W = 8, SUM_W = 20, VW = DIMS * CORD_W;
  logic clk = 0, rst = 1, run_start = 0, mode = 0, cent_valid = 0, result_ack = 0;
  logic [SUM_W-1:0] threshold = '0;
  logic [ITER_W-1:0] max_iter = '0;
  logic [2:0] cent_idx = '0;
  logic [VW-1:0] old_c = '0, new_c = '0, nco;
  logic ncv, rv, hc, lim, dup;
  logic [ITER_W-1:0] ic;
  logic [SUM_W-1:0] rs;
  int n_cmp = 0, n_bad = 0;

  convergence_check_unit dut (
    .clk(clk), .rst(rst), .run_start(run_start), .mode(mode), .threshold(threshold),
    .max_iter(max_iter), .cent_valid(cent_valid), .cent_idx(cent_idx),
    .old_centroid(old_c), .new_centroid_in(new_c), .new_centroid_out(nco),
    .new_centroid_valid(ncv), .result_valid(rv), .result_ack(result_ack),
    .has_converged(hc), .iter_limit_hit(lim), .dup_err(dup), .iter_count(ic), .round_sum(rs)
  );

  always #5 clk = ~clk;

  // Only coordinate 0 is non-zero, so the centroid distance is |o - n|.
  function automatic logic [VW-1:0] v0(input int c);
    v0 = '0;
    v0[CORD_W-1:0] = CORD_W'(c);
  endfunction

  task automatic send(input int idx, input int o, input int n);
    @(negedge clk);
    cent_valid = 1;
    cent_idx = 3'(idx);
    old_c = v0(o);
    new_c = v0(n);
  endtask

  task automatic send_all(input int o, input int n);
    for (int i = 0; i < 8; i++) send(i, o, n);
  endtask

  task automatic start();
    @(negedge clk); run_start = 1;
    @(negedge clk); run_start = 0;
  endtask

  task automatic end_round(input string tag);
    logic [2:0] seq;
    @(negedge clk); cent_valid = 0; seq[2] = rv;
    @(negedge clk); seq[1] = rv;
    @(negedge clk); seq[0] = rv;
    n_cmp++;
    if (seq !== 3'b001) begin
      n_bad++;
      $display("FAIL %s latency: result_valid seq %b want 001", tag, seq);
    end
  endtask

  task automatic ack(input string tag);
    @(negedge clk); result_ack = 1;
    @(negedge clk); result_ack = 0;
    n_cmp++;
    if (rv !== 1'b0) begin n_bad++; $display("FAIL %s ack_drop: result_valid %b want 0", tag, rv); end
  endtask

  task automatic idle_probe(input string tag, input logic [ITER_W-1:0] exp_ic);
    send_all(0, 5);
    @(negedge clk); cent_valid = 0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rv !== 1'b0 || ic !== exp_ic) begin
      n_bad++;
      $display("FAIL %s idle: result_valid %b iter %0d want 0 / %0d", tag, rv, ic, exp_ic);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rv, hc, lim, dup, ncv} !== 5'b0 || ic !== '0 || rs !== '0 || nco !== '0) begin
      n_bad++;
      $display("FAIL reset: rv%b hc%b lim%b dup%b ncv%b ic%0d rs%0d want all 0", rv, hc, lim, dup, ncv, ic, rs);
    end
    rst = 0;
  endtask

  task automatic test_passthrough();
    @(negedge clk); cent_valid = 1; new_c = v0(1234); new_c[VW-1 -: CORD_W] = 13'h0abc;
    @(negedge clk);
    n_cmp++;
    if (ncv !== 1'b1 || nco !== new_c) begin n_bad++; $display("FAIL passthrough: valid %b out %h want 1 %h", ncv, nco, new_c); end
    cent_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (ncv !== 1'b0) begin n_bad++; $display("FAIL passthrough_low: valid %b want 0", ncv); end
  endtask

  task automatic test_zero_diff();
    mode = 0; threshold = 4;
    start();
    send_all(100, 100);
    end_round("zero");
    n_cmp++;
    if (hc !== 1'b1 || rs !== 0 || ic !== 1 || lim !== 1'b0) begin
      n_bad++; $display("FAIL zero: conv %b sum %0d iter %0d lim %b want 1 0 1 0", hc, rs, ic, lim);
    end
    ack("zero");
    idle_probe("zero", 1);
  endtask

  task automatic test_extreme();
    mode = 0; threshold = 10;
    start();
    for (int i = 0; i < 8; i++) send(i, i == 5 ? -4096 : 7, i == 5 ? 4095 : 7);
    end_round("extreme");
    n_cmp++;
    if (hc !== 1'b0 || rs !== 8191 || ic !== 1) begin
      n_bad++; $display("FAIL extreme: conv %b sum %0d iter %0d want 0 8191 1", hc, rs, ic);
    end
    ack("extreme");
  endtask

  task automatic test_mode_sum();
    mode = 1; threshold = 20;
    start();
    send_all(2, 0);
    end_round("sum16");
    n_cmp++;
    if (hc !== 1'b1 || rs !== 16) begin n_bad++; $display("FAIL sum16: conv %b sum %0d want 1 16", hc, rs); end
    ack("sum16");
    start();
    send_all(-3, 0);
    end_round("sum24");
    n_cmp++;
    if (hc !== 1'b0 || rs !== 24 || ic !== 1) begin n_bad++; $display("FAIL sum24: conv %b sum %0d iter %0d want 0 24 1", hc, rs, ic); end
    ack("sum24");
    send_all(0, -2);
    end_round("next_round");
    n_cmp++;
    if (hc !== 1'b1 || rs !== 16 || ic !== 2) begin n_bad++; $display("FAIL next_round: conv %b sum %0d iter %0d want 1 16 2", hc, rs, ic); end
    ack("next_round");
  endtask

  task automatic test_duplicate();
    int order[9] = '{7, 0, 3, 3, 1, 2, 4, 5, 6};
    mode = 0; threshold = 10;
    start();
    n_cmp++;
    if (dup !== 1'b0) begin n_bad++; $display("FAIL dup_clear: dup %b want 0", dup); end
    for (int i = 0; i < 9; i++) send(order[i], i == 3 ? 5 : 1, 0);
    end_round("dup");
    n_cmp++;
    if (dup !== 1'b1 || rs !== 8 || hc !== 1'b1 || ic !== 1) begin
      n_bad++; $display("FAIL dup: dup %b sum %0d conv %b iter %0d want 1 8 1 1", dup, rs, hc, ic);
    end
    ack("dup");
    start();
    n_cmp++;
    if (dup !== 1'b0) begin n_bad++; $display("FAIL dup_restart: dup %b want 0", dup); end
  endtask

  task automatic test_iter_limit();
    mode = 0; threshold = 1; max_iter = 3;
    start();
    for (int r = 1; r <= 3; r++) begin
      send_all(1, 0);
      end_round("limit");
      n_cmp++;
      if (ic !== ITER_W'(r) || lim !== (r == 3) || hc !== 1'b0) begin
        n_bad++; $display("FAIL limit_r%0d: iter %0d lim %b conv %b want %0d %0d 0", r, ic, lim, hc, r, r == 3);
      end
      ack("limit");
    end
    idle_probe("limit", 3);
  endtask

  task automatic test_reset_mid_round();
    max_iter = 0;
    start();
    for (int i = 0; i < 4; i++) send(i, 5, 0);
    @(negedge clk); cent_valid = 0; rst = 1;
    #1;
    n_cmp++;
    if (rs !== '0 || {rv, lim, dup, ncv} !== 4'b0 || ic !== '0) begin
      n_bad++; $display("FAIL rst_mid: sum %0d rv%b lim%b dup%b ncv%b iter %0d want 0", rs, rv, lim, dup, ncv, ic);
    end
    @(negedge clk); rst = 0;
    mode = 1; threshold = 100;
    start();
    send_all(0, 1);
    end_round("after_rst");
    n_cmp++;
    if (rs !== 8 || hc !== 1'b1 || ic !== 1) begin n_bad++; $display("FAIL after_rst: sum %0d conv %b iter %0d want 8 1 1", rs, hc, ic); end
    ack("after_rst");
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_zero_diff();
    test_extreme();
    test_mode_sum();
    test_duplicate();
    test_iter_limit();
    test_reset_mid_round();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
